// File: rtl/uart_pll_rst_seq_if.sv
// Signal bundle between the PLL reset/lock sequencer (master) and the PLL/UART side (slave).
interface uart_pll_rst_seq_if;
   logic       pll_locked;
   logic       soft_req;
   logic       pll_rst;
   logic       user_rst;
   logic       ready;
   logic       fault;
   logic [3:0] retry_cnt;

   modport master (
      input  pll_locked, soft_req,
      output pll_rst, user_rst, ready, fault, retry_cnt
   );

   modport slave (
      output pll_locked, soft_req,
      input  pll_rst, user_rst, ready, fault, retry_cnt
   );
endinterface

// File: rtl/uart_pll_rst_seq.sv
// Reset/lock sequencer for the UART baud-clock PLL: pulses pll_rst, waits for a stable
// lock with timeout and bounded retries, then releases the UART-domain reset.
module uart_pll_rst_seq #(
   parameter int unsigned SYNC_STAGES    = 2,
   parameter int unsigned PLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT   = 50000,
   parameter int unsigned LOCK_STABLE    = 1024,
   parameter int unsigned MAX_RETRIES    = 3,
   parameter int unsigned CNT_W          = 16
) (
   input  logic                  refclk,
   input  logic                  rst,
   uart_pll_rst_seq_if.master    bus
);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABILIZE = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t                 state, state_n;
   logic [CNT_W-1:0]       cnt, cnt_n;
   logic [3:0]             retry, retry_n;
   logic [SYNC_STAGES-1:0] sync;
   logic                   locked_s;
   logic                   pll_rst_q, user_rst_q, ready_q, fault_q;
   logic                   pll_rst_n, user_rst_n, ready_n, fault_n;

   assign locked_s = sync[SYNC_STAGES-1];

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync <= '0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], bus.pll_locked};
      end
   end

   always_comb begin
      state_n = state;
      retry_n = retry;
      case (state)
         RESET_PLL: begin
            if (cnt == CNT_W'(PLL_RST_CYCLES - 1)) state_n = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_n = STABILIZE;
            end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
               if (retry == 4'(MAX_RETRIES)) begin
                  state_n = FAULT;
               end else begin
                  state_n = RESET_PLL;
                  retry_n = retry + 4'd1;
               end
            end
         end
         STABILIZE: begin
            if (!locked_s) state_n = WAIT_LOCK;
            else if (cnt == CNT_W'(LOCK_STABLE - 1)) state_n = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_n = RESET_PLL;
               retry_n = '0;
            end
         end
         FAULT: state_n = FAULT;
         default: state_n = RESET_PLL;
      endcase
      // soft_req overrides everything, including a restart of an ongoing pll_rst pulse
      if (bus.soft_req) begin
         state_n = RESET_PLL;
         retry_n = '0;
      end
   end

   always_comb begin
      cnt_n = cnt;
      if (bus.soft_req || state_n != state) cnt_n = '0;
      else if (state != RUN && state != FAULT) cnt_n = cnt + CNT_W'(1);
   end

   // Outputs decoded from the next state so they change on the edge that enters it
   always_comb begin
      pll_rst_n  = 1'b0;
      user_rst_n = 1'b1;
      ready_n    = 1'b0;
      fault_n    = 1'b0;
      case (state_n)
         RESET_PLL: pll_rst_n = 1'b1;
         RUN: begin
            user_rst_n = 1'b0;
            ready_n    = 1'b1;
         end
         FAULT: begin
            pll_rst_n = 1'b1;
            fault_n   = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state      <= RESET_PLL;
         cnt        <= '0;
         retry      <= '0;
         pll_rst_q  <= 1'b1;
         user_rst_q <= 1'b1;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         retry      <= retry_n;
         pll_rst_q  <= pll_rst_n;
         user_rst_q <= user_rst_n;
         ready_q    <= ready_n;
         fault_q    <= fault_n;
      end
   end

   assign bus.pll_rst   = pll_rst_q;
   assign bus.user_rst  = user_rst_q;
   assign bus.ready     = ready_q;
   assign bus.fault     = fault_q;
   assign bus.retry_cnt = retry;

endmodule

// File: tb/tb_uart_pll_rst_seq.sv
// Directed bench for uart_pll_rst_seq with short timing parameters; expected values
// are edge-counted by hand from the sequencer behaviour.
module tb_uart_pll_rst_seq;

   logic refclk = 1'b0;
   logic rst    = 1'b1;
   int unsigned checks = 0;
   int unsigned errors = 0;

   uart_pll_rst_seq_if bus ();

   uart_pll_rst_seq #(
      .SYNC_STAGES   (2),
      .PLL_RST_CYCLES(4),
      .LOCK_TIMEOUT  (20),
      .LOCK_STABLE   (8),
      .MAX_RETRIES   (2),
      .CNT_W         (16)
   ) dut (
      .refclk(refclk),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 refclk = ~refclk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp_v, $time);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // Assert rst between edges, check immediate reset values, release after one edge
   task automatic do_reset(input string tag);
      rst = 1'b1;
      bus.soft_req = 1'b0;
      #2;
      chk({tag, "_pll_rst"},  32'(bus.pll_rst),   1);
      chk({tag, "_user_rst"}, 32'(bus.user_rst),  1);
      chk({tag, "_ready"},    32'(bus.ready),     0);
      chk({tag, "_fault"},    32'(bus.fault),     0);
      chk({tag, "_retry"},    32'(bus.retry_cnt), 0);
      @(posedge refclk);
      #1;
      rst = 1'b0;
   endtask

   // Restart with pll_locked held high: pulse edges 1..3, WAIT at 4, STABILIZE at 5, RUN at 13
   task automatic restart_locked(input string tag);
      for (int e = 1; e <= 13; e++) begin
         tick();
         chk({tag, "_pll_rst"}, 32'(bus.pll_rst), 32'(e <= 3));
         chk({tag, "_ready"},   32'(bus.ready),   32'(e == 13));
      end
   endtask

   initial begin
      bus.pll_locked = 1'b0;
      bus.soft_req   = 1'b0;
      tick();

      // 1: nominal lock
      do_reset("t1_rst");
      for (int e = 1; e <= 3; e++) begin
         tick();
         chk("t1_pll_rst_hi", 32'(bus.pll_rst), 1);
      end
      tick();
      chk("t1_pll_rst_lo", 32'(bus.pll_rst), 0);
      tick();
      tick();
      bus.pll_locked = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("t1_ready",    32'(bus.ready),    32'(k == 10));
         chk("t1_user_rst", 32'(bus.user_rst), 32'(k != 10));
      end
      chk("t1_retry", 32'(bus.retry_cnt), 0);

      // 4: lock loss in RUN, then reacquire
      bus.pll_locked = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         tick();
         chk("t4_ready",    32'(bus.ready),    32'(k < 3));
         chk("t4_user_rst", 32'(bus.user_rst), 32'(k >= 3));
         chk("t4_pll_rst",  32'(bus.pll_rst),  32'(k >= 3 && k <= 6));
      end
      chk("t4_retry", 32'(bus.retry_cnt), 0);
      bus.pll_locked = 1'b1;
      tick();
      for (int k = 1; k <= 10; k++) begin
         tick();
         chk("t4_reacq_ready", 32'(bus.ready), 32'(k == 10));
      end

      // 6a: async reset during RUN
      do_reset("t6_run_rst");
      restart_locked("t6_run_restart");

      // 6b: async reset during STABILIZE (entered at edge 5)
      do_reset("t6_pre_rst");
      for (int e = 1; e <= 7; e++) tick();
      chk("t6_stab_pll_rst", 32'(bus.pll_rst), 0);
      chk("t6_stab_ready",   32'(bus.ready),   0);
      do_reset("t6_stab_rst");
      restart_locked("t6_stab_restart");

      // 2: never lock -> FAULT at edge 72
      bus.pll_locked = 1'b0;
      do_reset("t2_rst");
      for (int e = 1; e <= 80; e++) begin
         tick();
         chk("t2_pll_rst", 32'(bus.pll_rst),   32'((e >= 72) || ((e % 24) < 4)));
         chk("t2_fault",   32'(bus.fault),     32'(e >= 72));
         chk("t2_retry",   32'(bus.retry_cnt), (e >= 72) ? 32'd2 : 32'(e / 24));
         chk("t2_user_rst", 32'(bus.user_rst), 1);
      end

      // 5: soft_req recovers from FAULT
      bus.soft_req = 1'b1;
      tick();
      bus.soft_req = 1'b0;
      chk("t5_fault",   32'(bus.fault),     0);
      chk("t5_retry",   32'(bus.retry_cnt), 0);
      chk("t5_pll_rst", 32'(bus.pll_rst),   1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t5_pulse", 32'(bus.pll_rst), 32'(k < 4));
      end
      for (int k = 5; k <= 23; k++) tick();
      // soft_req on the timeout edge: retry must clear rather than step to 1
      bus.soft_req = 1'b1;
      tick();
      bus.soft_req = 1'b0;
      chk("t5_to_pll_rst", 32'(bus.pll_rst),   1);
      chk("t5_to_retry",   32'(bus.retry_cnt), 0);
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk("t5_to_pulse", 32'(bus.pll_rst), 32'(k < 4));
      end
      // soft_req on the edge where locked_s would move WAIT_LOCK to STABILIZE
      bus.pll_locked = 1'b1;
      tick();
      tick();
      bus.soft_req = 1'b1;
      tick();
      bus.soft_req = 1'b0;
      chk("t5_lk_pll_rst", 32'(bus.pll_rst),  1);
      chk("t5_lk_user_rst", 32'(bus.user_rst), 1);
      for (int k = 4; k <= 16; k++) begin
         tick();
         chk("t5_lk_pulse", 32'(bus.pll_rst), 32'(k <= 6));
         chk("t5_lk_ready", 32'(bus.ready),   32'(k == 16));
      end

      // 3: one-cycle glitch in STABILIZE after one consumed retry
      bus.pll_locked = 1'b0;
      do_reset("t3_rst");
      for (int e = 1; e <= 28; e++) tick();
      chk("t3_pre_retry",   32'(bus.retry_cnt), 1);
      chk("t3_pre_pll_rst", 32'(bus.pll_rst),   0);
      bus.pll_locked = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         tick();
         chk("t3_pll_rst", 32'(bus.pll_rst),   0);
         chk("t3_retry",   32'(bus.retry_cnt), 1);
         chk("t3_ready",   32'(bus.ready),     32'(k == 16));
         if (k == 4) bus.pll_locked = 1'b0;
         if (k == 5) bus.pll_locked = 1'b1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_pll_rst_seq.md
Name: uart_pll_rst_seq

Overview:
- Reset/lock sequencer for the UART baud-clock PLL (50 MHz ref -> 1.8432 MHz).
- Pulses the PLL reset, waits for lock with a timeout, and requires lock to stay stable before releasing the UART-domain reset.
- Retries a bounded number of times, then latches a fault; re-sequences on lock loss or software request.
- Sits between the board reset and the PLL wrapper, in the refclk domain.

Parameters:
- SYNC_STAGES, 2, synchronizer depth for the asynchronous pll_locked input (>=2).
- PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000, max refclk cycles spent in WAIT_LOCK per attempt (>=1).
- LOCK_STABLE, 1024, consecutive synchronized-locked cycles required before release (>=1).
- MAX_RETRIES, 3, re-attempts after the first before FAULT (0..15).
- CNT_W, 16, internal counter width; must hold max(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE).

Ports:
- refclk  in  1  free-running reference clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- pll_locked  in  1  PLL locked output; asynchronous to refclk.
- soft_req  in  1  single-cycle pulse requesting a full re-sequence.
- pll_rst  out  1  PLL reset (active-high).
- user_rst  out  1  UART-domain reset request (active-high).
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- retry_cnt  out  4  retries consumed in the current acquisition.

Behaviour:
- rst asserted: immediately forces state=RESET_PLL, counter=0, sync chain=0, retry_cnt=0, pll_rst=1, user_rst=1, ready=0, fault=0. This applies from any state, including mid-sequence.
- locked_s is pll_locked delayed through SYNC_STAGES flops. Only locked_s is used in the FSM.
- All outputs are registered Moore decodes of the state, so they change on the edge that enters the new state.
- Output decode per state (pll_rst / user_rst / ready / fault):
  - RESET_PLL: 1/1/0/0
  - WAIT_LOCK: 0/1/0/0
  - STABILIZE: 0/1/0/0
  - RUN: 0/0/1/0
  - FAULT: 1/1/0/1
- Counter clears on every state change.
- RESET_PLL: counts cycles; at count==PLL_RST_CYCLES-1 -> WAIT_LOCK. pll_rst is therefore high for exactly PLL_RST_CYCLES cycles.
- WAIT_LOCK transitions:
  - locked_s=1 -> STABILIZE.
  - Else, at count==LOCK_TIMEOUT-1:
    - retry_cnt==MAX_RETRIES -> FAULT.
    - Otherwise retry_cnt+1 and -> RESET_PLL.
  - If locked_s rises on the timeout cycle, the lock wins.
- STABILIZE transitions:
  - locked_s=0 -> WAIT_LOCK; timeout restarts, no retry increment.
  - At count==LOCK_STABLE-1 with locked_s=1 -> RUN.
  - Consequence: ready rises exactly SYNC_STAGES+LOCK_STABLE edges after the edge that first samples pll_locked=1, given no glitch.
- RUN: on locked_s=0 -> RESET_PLL with retry_cnt=0. user_rst=1 and ready=0 are asserted SYNC_STAGES+1 edges after pll_locked falls.
- FAULT: held indefinitely. Exits only via soft_req or rst.
- soft_req=1 in any state: next state RESET_PLL, counter=0, retry_cnt=0. soft_req has priority over every other transition in the same cycle.
  - In RESET_PLL it restarts the pulse count, extending pll_rst.
- retry_cnt saturates by construction (never exceeds MAX_RETRIES). It holds its value in RUN and FAULT.
- No combinational path from any input to any output.

Test Plan:
Bench parameters: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, MAX_RETRIES=2.
1. Nominal lock: release rst, drive pll_locked=1 from the 3rd WAIT_LOCK cycle onward.
   - Required: pll_rst high exactly 4 cycles.
   - Required: ready=1 and user_rst=0 exactly 10 edges after first sample of locked=1.
   - Required: retry_cnt=0.
2. Never lock: hold pll_locked=0.
   - Required: three 4-cycle pll_rst pulses, each followed by 20 WAIT_LOCK cycles.
   - Required: retry_cnt steps 0->1->2; fault=1 and pll_rst=1 from edge 72 onward, held.
3. Glitch in STABILIZE: locked=1 for 5 synchronized cycles, then 0 for 1 cycle, then 1.
   - Required: return to WAIT_LOCK, retry_cnt unchanged, no pll_rst pulse.
   - Required: ready delayed to 10 edges after the re-rise.
4. Lock loss in RUN: drop pll_locked.
   - Required: ready=0 and user_rst=1 at edge 3, followed by a 4-cycle pll_rst pulse.
   - Required: reacquisition per test 1 when locked returns.
5. Recovery from FAULT: pulse soft_req for 1 cycle.
   - Required: next edge fault=0, retry_cnt=0, pll_rst=1 for 4 cycles.
   - Simultaneous case: soft_req coinciding with the WAIT_LOCK timeout or with locked_s rising still goes to RESET_PLL.
6. Mid-sequence reset: assert rst asynchronously (between edges) during STABILIZE and during RUN.
   - Required: outputs reach reset values before the next edge.
   - Required: after release, the sequence restarts from RESET_PLL.
